// File: rtl/mon_cdc_arbiter.sv
// Round-robin sequencer sharing one CDC synchronizer write channel
// between NREQ monitor sources, with a stalled-read-clock timeout.
module mon_cdc_arbiter #(
  parameter int DSIZE = 34,
  parameter int NREQ = 4,
  parameter int TIMEOUT = 255,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                  WrClk,
  input  logic                  WrRstN,
  input  logic                  Enable,
  input  logic [NREQ-1:0]       Req,
  input  logic [NREQ*DSIZE-1:0] ReqData,
  output logic [NREQ-1:0]       Ack,
  output logic [NREQ-1:0]       Done,
  output logic [IDW-1:0]        GrantId,
  output logic                  Busy,
  output logic                  TimeoutErr,
  output logic [DSIZE-1:0]      SyncData,
  output logic                  SyncWrite,
  input  logic                  SyncWriteDone
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    GAP
  } state_t;

  state_t state, state_n;

  logic [IDW-1:0]   ptr, ptr_n, ptr_inc;
  logic [15:0]      cnt, cnt_n;
  logic             wd_q, done_edge;
  logic [IDW-1:0]   win, gid_n;
  logic             found;
  logic [NREQ-1:0]  ack_n, done_n;
  logic             tmo_n, wr_n;
  logic [DSIZE-1:0] data_n;

  assign done_edge = SyncWriteDone & ~wd_q;
  assign ptr_inc   = (GrantId == IDW'(NREQ - 1)) ? '0 : GrantId + 1'b1;

  // Search from the RR pointer, wrapping, first set request wins
  always_comb begin
    int j;
    j     = 0;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(ptr) + i) % NREQ;
      if (!found && Req[j]) begin
        found = 1'b1;
        win   = IDW'(j);
      end
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    gid_n   = GrantId;
    data_n  = SyncData;
    ack_n   = '0;
    done_n  = '0;
    tmo_n   = 1'b0;
    wr_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (Enable && found) begin
          state_n    = BUSY;
          data_n     = ReqData[int'(win)*DSIZE +: DSIZE];
          wr_n       = 1'b1;
          ack_n[win] = 1'b1;
          gid_n      = win;
          cnt_n      = '0;
        end
      end
      BUSY: begin
        if (done_edge) begin
          done_n[GrantId] = 1'b1;
          ptr_n           = ptr_inc;
          state_n         = GAP;
        end else if (cnt == 16'(TIMEOUT - 1)) begin
          done_n[GrantId] = 1'b1;
          tmo_n           = 1'b1;
          ptr_n           = ptr_inc;
          state_n         = GAP;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      GAP: begin
        // A stretched WriteDone must drop before the next grant
        if (!SyncWriteDone) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge WrClk or negedge WrRstN) begin
    if (!WrRstN) begin
      state      <= IDLE;
      ptr        <= '0;
      cnt        <= '0;
      wd_q       <= 1'b0;
      Ack        <= '0;
      Done       <= '0;
      GrantId    <= '0;
      Busy       <= 1'b0;
      TimeoutErr <= 1'b0;
      SyncData   <= '0;
      SyncWrite  <= 1'b0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      cnt        <= cnt_n;
      wd_q       <= SyncWriteDone;
      Ack        <= ack_n;
      Done       <= done_n;
      GrantId    <= gid_n;
      Busy       <= (state_n != IDLE);
      TimeoutErr <= tmo_n;
      SyncData   <= data_n;
      SyncWrite  <= wr_n;
    end
  end

endmodule
